// File: rtl/irda_rx_fifo_pkg.sv
// Shared IrDA FIFO definitions.
// IRDA_FIFO_POINTER_W is also used by the TX FIFO and the interrupt block.
// rx_entry_t is one stored FIFO word: the EOF tag above the received byte.
package irda_rx_fifo_pkg;

  localparam int unsigned IRDA_FIFO_POINTER_W = 4;
  localparam int unsigned RX_DATA_W           = 8;
  localparam int unsigned RX_ENTRY_W          = RX_DATA_W + 1;

  typedef struct packed {
    logic                 eof;
    logic [RX_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/irda_rx_fifo_if.sv
// Interface for the receive FIFO: push side from the FIR/MIR deframers,
// pop side from the Wishbone/DMA read path, status to the interrupt block.
//   slave  : the FIFO (takes strobes, drives data/status)
//   master : the FIFO's user (drives strobes, takes data/status)
interface irda_rx_fifo_if
  import irda_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W         = RX_DATA_W,
  parameter int unsigned FIFO_POINTER_W = IRDA_FIFO_POINTER_W
) ();

  logic                    fifo_clear;
  logic                    push;
  logic [DATA_W-1:0]       push_data;
  logic                    push_eof;
  logic                    pop;
  logic [DATA_W-1:0]       pop_data;
  logic                    pop_eof;
  logic [FIFO_POINTER_W:0] rxfifo_count;
  logic                    rxfifo_overrun;
  logic                    empty;
  logic                    full;

  modport slave (
    input  fifo_clear, push, push_data, push_eof, pop,
    output pop_data, pop_eof, rxfifo_count, rxfifo_overrun, empty, full
  );

  modport master (
    output fifo_clear, push, push_data, push_eof, pop,
    input  pop_data, pop_eof, rxfifo_count, rxfifo_overrun, empty, full
  );

endinterface

// File: rtl/irda_fifo_mem.sv
// Storage array for the IrDA FIFOs: 2**ADDR_W words of WIDTH bits.
// One synchronous write port, one asynchronous read port. Contents are not
// reset. Shared with the TX FIFO, where the EOF bit is left unused.
//   clk   : write clock
//   we    : write enable
//   waddr : write index      wdata : write word
//   raddr : read index       rdata : word at raddr (combinational)
module irda_fifo_mem #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/irda_rx_fifo.sv
// IrDA receive FIFO: 16 bytes, each tagged with an end-of-frame bit.
// Ports:
//   clk      : system clock
//   wb_rst_i : asynchronous active-high reset
//   bus      : irda_rx_fifo_if.slave -- fifo_clear, push/push_data/push_eof,
//              pop, registered pop_data/pop_eof, rxfifo_count, one-cycle
//              rxfifo_overrun pulse, empty, full
// Occupancy lives in its own register; pointers wrap naturally.
module irda_rx_fifo
  import irda_rx_fifo_pkg::*;
(
  input  logic           clk,
  input  logic           wb_rst_i,
  irda_rx_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = IRDA_FIFO_POINTER_W;
  localparam logic [PTR_W:0] FULL_CNT = {1'b1, {PTR_W{1'b0}}};

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [RX_DATA_W-1:0] pop_data_q, pop_data_d;
  logic                 pop_eof_q, pop_eof_d;
  logic                 overrun_q, overrun_d;

  logic      push_ok;
  logic      pop_ok;
  rx_entry_t wr_entry;
  rx_entry_t rd_entry;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push alongside an accepted pop; an empty FIFO never pops.
  assign pop_ok   = bus.pop  && (count_q != '0) && !bus.fifo_clear;
  assign push_ok  = bus.push && ((count_q != FULL_CNT) || pop_ok) && !bus.fifo_clear;
  assign wr_entry = '{eof: bus.push_eof, data: bus.push_data};

  irda_fifo_mem #(
    .WIDTH  (RX_ENTRY_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop_data_d = pop_data_q;
    pop_eof_d  = pop_eof_q;
    overrun_d  = 1'b0;

    if (bus.fifo_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        pop_data_d = rd_entry.data;
        pop_eof_d  = rd_entry.eof;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
      overrun_d = bus.push && !push_ok;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pop_data_q <= '0;
      pop_eof_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pop_data_q <= pop_data_d;
      pop_eof_q  <= pop_eof_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.pop_data       = pop_data_q;
  assign bus.pop_eof        = pop_eof_q;
  assign bus.rxfifo_count   = count_q;
  assign bus.rxfifo_overrun = overrun_q;
  assign bus.empty          = (count_q == '0);
  assign bus.full           = (count_q == FULL_CNT);

endmodule

// File: tb/tb_irda_rx_fifo.sv
// Bench for irda_rx_fifo. Inputs change on the falling edge; a queue model
// steps on the rising edge; a monitor on the falling edge compares popped
// entries from the scoreboard queue and the status outputs to the model.
module tb_irda_rx_fifo;
  import irda_rx_fifo_pkg::*;

  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;
  always #5 clk = ~clk;

  irda_rx_fifo_if bus ();

  irda_rx_fifo dut (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of {eof,data} words, capacity 16.
  logic [8:0] mq[$];
  logic [8:0] exp_q[$];
  logic [8:0] last_out = '0;
  bit         m_ovr    = 1'b0;
  bit         pop_flag = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    last_out = '0;
    m_ovr    = 1'b0;
    pop_flag = 1'b0;
  endtask

  // Model step at each rising edge.
  initial begin
    logic [8:0] e;
    bit popping, pushing;
    forever begin
      @(posedge clk);
      if (wb_rst_i) begin
        model_reset();
      end else if (bus.fifo_clear) begin
        mq.delete();
        m_ovr = 1'b0;
      end else begin
        popping = bus.pop && (mq.size() > 0);
        pushing = bus.push && (mq.size() < 16 || popping);
        if (popping) begin
          e = mq.pop_front();
          exp_q.push_back(e);
          last_out = e;
          pop_flag = 1'b1;
        end
        if (pushing) mq.push_back({bus.push_eof, bus.push_data});
        m_ovr = bus.push && !pushing;
      end
    end
  end

  // Monitor on the falling edge.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (pop_flag) begin
        pop_flag = 1'b0;
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("pop_entry", {23'd0, bus.pop_eof, bus.pop_data}, {23'd0, e});
        end
      end
      chk("count",   {27'd0, bus.rxfifo_count}, mq.size());
      chk("empty",   {31'd0, bus.empty},          {31'd0, mq.size() == 0});
      chk("full",    {31'd0, bus.full},           {31'd0, mq.size() == 16});
      chk("overrun", {31'd0, bus.rxfifo_overrun}, {31'd0, m_ovr});
      chk("out_hold", {23'd0, bus.pop_eof, bus.pop_data}, {23'd0, last_out});
    end
  end

  task automatic cyc(input bit ps, input logic [7:0] d, input bit e,
                     input bit pp, input bit clr);
    bus.push       = ps;
    bus.push_data  = d;
    bus.push_eof   = e;
    bus.pop        = pp;
    bus.fifo_clear = clr;
    @(negedge clk);
  endtask

  initial begin
    bus.push = 0; bus.push_data = '0; bus.push_eof = 0;
    bus.pop = 0; bus.fifo_clear = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", {27'd0, bus.rxfifo_count}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    wb_rst_i = 1'b0;
    @(negedge clk);

    // Two pushes then two pops.
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 1, 0, 0);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t1_first", {24'd0, bus.pop_data}, 32'h11);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t1_second", {23'd0, bus.pop_eof, bus.pop_data}, 32'h122);
    cyc(0, 8'h00, 0, 0, 0);

    // Fill, overrun, drain.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("t2_full", {31'd0, bus.full}, 32'd1);
    cyc(1, 8'hAA, 0, 0, 0);
    chk("t2_ovr", {31'd0, bus.rxfifo_overrun}, 32'd1);
    cyc(0, 8'h00, 0, 0, 0);
    chk("t2_ovr_drop", {31'd0, bus.rxfifo_overrun}, 32'd0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("t2_last", {24'd0, bus.pop_data}, 32'h0F);

    // Full with simultaneous push and pop across the wrap.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), i[0], 0, 0);
    for (int i = 0; i < 4; i++)  cyc(1, 8'(8'hC0 + i), 0, 1, 0);
    chk("t3_count", {27'd0, bus.rxfifo_count}, 32'd16);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("t3_last", {24'd0, bus.pop_data}, 32'hC3);

    // Empty with simultaneous push and pop: no bypass.
    cyc(1, 8'h55, 0, 1, 0);
    chk("t4_nobypass", {24'd0, bus.pop_data}, 32'hC3);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t4_pop", {24'd0, bus.pop_data}, 32'h55);
    cyc(0, 8'h00, 0, 0, 0);

    // Clear with push high, then pop on empty.
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
    cyc(1, 8'h99, 0, 1, 1);
    chk("t5_clr", {27'd0, bus.rxfifo_count}, 32'd0);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t5_hold", {24'd0, bus.pop_data}, 32'h55);

    // Asynchronous reset mid-cycle with data present.
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0, i == 2, 0);
    bus.push = 0; bus.pop = 0;
    @(posedge clk);
    #2;
    wb_rst_i = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_count", {27'd0, bus.rxfifo_count}, 32'd0);
    chk("t6_rst_data",  {24'd0, bus.pop_data}, 32'd0);
    @(negedge clk);
    wb_rst_i = 1'b0;
    cyc(1, 8'h3C, 1, 0, 0);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t6_roundtrip", {23'd0, bus.pop_eof, bus.pop_data}, 32'h13C);

    // Randomized traffic, phases biased toward filling, draining, mixing.
    for (int i = 0; i < 3000; i++) begin
      int unsigned ph;
      int unsigned pw, pr;
      ph = (i / 150) % 3;
      pw = (ph == 0) ? 85 : (ph == 1) ? 20 : 55;
      pr = (ph == 0) ? 20 : (ph == 1) ? 85 : 55;
      cyc($urandom_range(99) < pw, 8'($urandom), 1'($urandom),
          $urandom_range(99) < pr, $urandom_range(127) == 0);
    end
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irda_rx_fifo.md
Name: irda_rx_fifo

Overview:
Receive FIFO between the FIR/MIR receive deframers and the Wishbone read path. Stores received bytes, each tagged with an end-of-frame marker. Provides the occupancy count and an overrun pulse to the interrupt/DMA block, which compares the count against its trigger levels and latches overrun into status. Software or DMA drains the FIFO through registered pops.

Parameters:
DATA_W, 8, received byte width
FIFO_POINTER_W, 4, pointer width; depth = 2**FIFO_POINTER_W = 16

Ports:
clk  input  1  system clock
wb_rst_i  input  1  reset; asynchronous, active-high
fifo_clear  input  1  synchronous flush (from FIFO control register write)
push  input  1  write strobe from active receiver (FIR or MIR)
push_data  input  DATA_W  byte to store
push_eof  input  1  tag: byte is last of frame
pop  input  1  read strobe (Wishbone data-register read or DMA ack)
pop_data  output  DATA_W  registered head byte
pop_eof  output  1  registered head EOF tag
rxfifo_count  output  FIFO_POINTER_W+1  occupancy, 0..16
rxfifo_overrun  output  1  one-cycle pulse: push dropped while full
empty  output  1  rxfifo_count == 0
full  output  1  rxfifo_count == 16

Behaviour:
- Reset (async, wb_rst_i high): wr_ptr = rd_ptr = 0, count = 0, pop_data = 0, pop_eof = 0, rxfifo_overrun = 0. Storage contents are not reset.
- Storage: 16 x (DATA_W+1) array. wr_ptr and rd_ptr are FIFO_POINTER_W bits and wrap 15 -> 0 naturally. Count is held in a separate register, not derived from the pointers.
- Push accepted when push=1 and (count < 16, or pop is accepted in the same cycle):
  - {push_eof, push_data} written at wr_ptr.
  - wr_ptr increments.
- Pop accepted when pop=1 and count > 0:
  - pop_data and pop_eof load from the entry at rd_ptr on the same edge; visible the next cycle (1-cycle latency).
  - rd_ptr increments.
- Pop when empty: ignored. pop_data and pop_eof hold; no pointer or count change.
- Count update per cycle:
  - +1 on push only
  - -1 on pop only
  - unchanged on both or neither
  - never exceeds 16, never below 0
- Full with simultaneous push and pop: both accepted, count stays 16, no overrun. Write and read target the same index only when count is 0 or 16. At 16, the read uses the old contents.
- Empty with simultaneous push and pop: pop ignored, push accepted, count becomes 1. No bypass of push_data to pop_data.
- Overrun: push=1 with count == 16 and no accepted pop:
  - data dropped, pointers unchanged
  - rxfifo_overrun = 1 for the following cycle only
  - back-to-back dropped pushes produce back-to-back pulses
- fifo_clear (synchronous, highest priority after reset):
  - pointers and count set to 0, rxfifo_overrun set to 0
  - pop_data and pop_eof hold their value
  - push and pop in the same cycle are ignored
- Reset mid-frame: all state returns to reset values immediately; no partial-entry recovery.
- rxfifo_count, empty and full are registered-derived with no combinational path from push or pop. The count changes one edge after the strobe.

Decomposition:
- Shared defines: IRDA_FIFO_POINTER_W (= 4). The TX FIFO and interrupt block use the same value.
- Sub-module irda_fifo_mem: 16 x 9 storage with one synchronous write port and one asynchronous read port. It is reused later for the TX FIFO with the EOF tag unused.
- Pointer, count and overrun logic stay in irda_rx_fifo.

Test Plan:
- Reset then push 0x11, 0x22 (eof=1 on 0x22) -> count 1, 2 on successive edges; pop twice -> pop_data 0x11 then 0x22, pop_eof 0 then 1, count back to 0, empty=1.
- Push 16 bytes 0x00..0x0F -> full=1, count=16; 17th push 0xAA -> rxfifo_overrun high exactly one cycle, count stays 16; pop 16 -> sequence 0x00..0x0F with no 0xAA.
- Fill to 16, assert push and pop together for 4 cycles -> count remains 16, no overrun, output order preserved across pointer wrap.
- Empty FIFO, push 0x55 and pop same cycle -> count=1, pop_data unchanged; next pop -> pop_data=0x55.
- Fill to 9, assert fifo_clear with push high -> count=0, empty=1, overrun=0; subsequent pop ignored, pop_data holds last value.
- Push 5 bytes, assert wb_rst_i asynchronously mid-cycle -> count, pointers and pop_data go to 0 immediately; after release, a push/pop of 0x3C round-trips correctly.
